// File: rtl/act_window_buffer_pkg.sv
// Shared geometry, mode codes and config record for the activation window buffer.
// N_LANES / DATA_W / STRIDE_MAX are set here; every derived width follows from them.
package act_window_buffer_pkg;

  localparam int N_LANES    = 8;
  localparam int DATA_W     = 8;
  localparam int STRIDE_MAX = 2;
  localparam int DEPTH      = STRIDE_MAX * N_LANES;
  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int AW         = $clog2(DEPTH);
  localparam int SW         = $clog2(STRIDE_MAX) + 1;
  localparam int LCW        = $clog2(N_LANES) + 1;

  localparam logic [2:0] MODE_FC  = 3'd0;
  localparam logic [2:0] MODE_CNN = 3'd1;
  localparam logic [2:0] MODE_EWS = 3'd2;

  typedef logic signed [DATA_W-1:0] act_t;

  typedef struct packed {
    logic [2:0]       mode;
    logic [SW-1:0]    stride;
    logic [SW-1:0]    up_log2;
    logic [CNT_W-1:0] advance;
  } awb_cfg_t;

  // Strided zero-insertion is not supported; such configs fall back to a plain window.
  function automatic logic cfg_illegal(input awb_cfg_t c);
    return (c.stride == '0) ||
           (int'(c.stride) > STRIDE_MAX) ||
           ((c.stride > SW'(1)) && (c.up_log2 != '0)) ||
           ((32'd1 << c.up_log2) > 32'(STRIDE_MAX));
  endfunction

  function automatic logic is_bypass(input logic [2:0] mode);
    return (mode == MODE_FC) || (mode == MODE_EWS);
  endfunction

endpackage

// File: rtl/act_window_mux.sv
// Combinational lane selector: per-lane storage address, zero-insert mask and window span.
// Zero latency; no handshake of its own.
module act_window_mux #(
  parameter int N_LANES    = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int SW         = 2,
  parameter int CNT_W      = 5
) (
  input  logic [AW-1:0]         rd_ptr_i,
  input  logic [SW-1:0]         phase_i,
  input  logic [SW-1:0]         stride_i,
  input  logic [SW-1:0]         up_log2_i,
  output logic [N_LANES*AW-1:0] lane_addr_o,
  output logic [N_LANES-1:0]    lane_zero_o,
  output logic [CNT_W-1:0]      span_o
);

  localparam int OW = CNT_W + 1;

  logic [OW-1:0] v;
  logic [OW-1:0] off;
  logic [OW-1:0] addr;
  logic [OW-1:0] mask;

  always_comb begin
    lane_addr_o = '0;
    lane_zero_o = '0;
    v           = '0;
    off         = '0;
    addr        = '0;
    mask        = (OW'(1) << up_log2_i) - OW'(1);
    for (int i = 0; i < N_LANES; i++) begin
      v = OW'(phase_i) + OW'(i);
      if (up_log2_i == '0) begin
        off = OW'(i) * OW'(stride_i);
      end else begin
        // Virtual position v maps to stored word v>>up; off-grid positions are inserted zeros.
        off            = v >> up_log2_i;
        lane_zero_o[i] = |(v & mask);
      end
      addr = OW'(rd_ptr_i) + off;
      if (addr >= OW'(DEPTH)) addr = addr - OW'(DEPTH);
      lane_addr_o[i*AW +: AW] = addr[AW-1:0];
    end
    if (up_log2_i == '0) span_o = CNT_W'(N_LANES - 1) * CNT_W'(stride_i) + CNT_W'(1);
    else                 span_o = ((CNT_W'(phase_i) + CNT_W'(N_LANES - 1)) >> up_log2_i) + CNT_W'(1);
  end

endmodule

// File: rtl/act_window_buffer.sv
// Circular activation store presenting a strided / zero-inserted N_LANES window; FC/EWS bypass.
// Window visible the cycle after the completing push; in_ready is conservative (pre-pop fill).
module act_window_buffer
  import act_window_buffer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [2:0]                cfg_mode,
  input  logic [SW-1:0]             cfg_stride,
  input  logic [SW-1:0]             cfg_up_log2,
  input  logic [CNT_W-1:0]          cfg_advance,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LCW-1:0]            in_count,
  input  logic [N_LANES*DATA_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]          fill_level,
  output logic                      err
);

  act_t             buf_q [DEPTH];
  act_t             buf_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             err_q, err_d;
  awb_cfg_t         cfg_q, cfg_in;

  logic                      bypass, cfg_ok, win_vld, room_ok;
  logic                      push_fire, pop_fire, cnt_bad, pop_over;
  logic [SW-1:0]             stride_eff, up_eff;
  logic [N_LANES*AW-1:0]     lane_addr;
  logic [N_LANES-1:0]        lane_zero;
  logic [CNT_W-1:0]          span, push_n, pop_n, wsum, rsum, asum;
  logic [CNT_W:0]            tsum, pop_req;
  logic [N_LANES*DATA_W-1:0] win_dat;

  assign cfg_in     = '{mode: cfg_mode, stride: cfg_stride, up_log2: cfg_up_log2, advance: cfg_advance};
  assign bypass     = is_bypass(cfg_q.mode);
  assign cfg_ok     = !cfg_illegal(cfg_q);
  assign stride_eff = cfg_ok ? cfg_q.stride : SW'(1);
  assign up_eff     = cfg_ok ? cfg_q.up_log2 : '0;

  act_window_mux #(
    .N_LANES (N_LANES),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .SW      (SW),
    .CNT_W   (CNT_W)
  ) u_mux (
    .rd_ptr_i    (rd_ptr_q),
    .phase_i     (phase_q),
    .stride_i    (stride_eff),
    .up_log2_i   (up_eff),
    .lane_addr_o (lane_addr),
    .lane_zero_o (lane_zero),
    .span_o      (span)
  );

  assign win_vld = (fill_q >= span);
  assign room_ok = ((CNT_W'(DEPTH) - fill_q) >= CNT_W'(in_count));

  always_comb begin
    win_dat = '0;
    for (int i = 0; i < N_LANES; i++)
      win_dat[i*DATA_W +: DATA_W] = lane_zero[i] ? '0 : buf_q[lane_addr[i*AW +: AW]];
  end

  assign in_ready   = bypass ? out_ready : room_ok;
  assign out_valid  = bypass ? in_valid  : win_vld;
  assign out_data   = bypass ? in_data   : (win_vld ? win_dat : '0);
  assign fill_level = fill_q;
  assign err        = err_q;

  always_comb begin
    cnt_bad   = (in_count > LCW'(N_LANES));
    push_fire = !bypass && in_valid && room_ok;
    pop_fire  = !bypass && win_vld && out_ready;
    push_n    = (push_fire && !cnt_bad) ? CNT_W'(in_count) : '0;
    tsum      = (CNT_W+1)'(phase_q) + (CNT_W+1)'(cfg_q.advance);
    pop_req   = (up_eff == '0) ? {1'b0, cfg_q.advance} : (tsum >> up_eff);
    pop_over  = (pop_req > {1'b0, fill_q});
    pop_n     = '0;
    if (pop_fire) pop_n = pop_over ? fill_q : pop_req[CNT_W-1:0];
    phase_d = phase_q;
    if (pop_fire && (up_eff != '0)) phase_d = tsum[SW-1:0] & ((SW'(1) << up_eff) - SW'(1));
    fill_d = fill_q + push_n - pop_n;

    wsum = CNT_W'(wr_ptr_q) + push_n;
    if (wsum >= CNT_W'(DEPTH)) wsum = wsum - CNT_W'(DEPTH);
    wr_ptr_d = wsum[AW-1:0];
    rsum = CNT_W'(rd_ptr_q) + pop_n;
    if (rsum >= CNT_W'(DEPTH)) rsum = rsum - CNT_W'(DEPTH);
    rd_ptr_d = rsum[AW-1:0];

    buf_d = buf_q;
    asum  = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (CNT_W'(k) < push_n) begin
        asum = CNT_W'(wr_ptr_q) + CNT_W'(k);
        if (asum >= CNT_W'(DEPTH)) asum = asum - CNT_W'(DEPTH);
        buf_d[asum[AW-1:0]] = in_data[k*DATA_W +: DATA_W];
      end
    end

    err_d = err_q | (push_fire & cnt_bad) | (pop_fire & pop_over);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) buf_q[j] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      phase_q  <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
      cfg_q    <= '{mode: MODE_CNN, stride: SW'(1), up_log2: '0, advance: CNT_W'(1)};
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      phase_q  <= '0;
      fill_q   <= '0;
      err_q    <= cfg_illegal(cfg_in);
      cfg_q    <= cfg_in;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      phase_q  <= phase_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_act_window_buffer.sv
// Directed bench for act_window_buffer (8 lanes, 8-bit, STRIDE_MAX 2, depth 16).
module tb_act_window_buffer;
  import act_window_buffer_pkg::*;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [2:0]  cfg_mode;
  logic [1:0]  cfg_stride;
  logic [1:0]  cfg_up_log2;
  logic [4:0]  cfg_advance;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_count;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  fill_level;
  logic        err;

  int total = 0;
  int bad   = 0;

  act_window_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .cfg_mode    (cfg_mode),
    .cfg_stride  (cfg_stride),
    .cfg_up_log2 (cfg_up_log2),
    .cfg_advance (cfg_advance),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_count    (in_count),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .fill_level  (fill_level),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ramp(input int s, input int d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(s + i * d);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [2:0] m, input int s, input int u, input int a);
    cfg_mode    = m;
    cfg_stride  = 2'(s);
    cfg_up_log2 = 2'(u);
    cfg_advance = 5'(a);
    clear       = 1'b1;
    tick();
    clear = 1'b0;
    #1;
  endtask

  task automatic push(input logic [63:0] d, input int c);
    in_valid = 1'b1;
    in_data  = d;
    in_count = 4'(c);
    tick();
    in_valid = 1'b0;
    in_count = '0;
    #1;
  endtask

  task automatic pop(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; cfg_mode = MODE_CNN; cfg_stride = 2'd1; cfg_up_log2 = 2'd0;
    cfg_advance = 5'd1; in_valid = 1'b0; in_count = '0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fill", fill_level, 0);
    chk("rst_err", err, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b1;
    #1;

    // Stride 1
    do_clear(MODE_CNN, 1, 0, 1);
    push(ramp(0, 1), 8);
    chk("s1_valid", out_valid, 1);
    chk("s1_data", out_data, ramp(0, 1));
    out_ready = 1'b1; in_valid = 1'b1; in_count = 4'd1; in_data = 64'h08;
    tick();
    out_ready = 1'b0; in_valid = 1'b0; in_count = '0;
    #1;
    chk("s1_pop_push_data", out_data, ramp(1, 1));
    chk("s1_pop_push_fill", fill_level, 8);

    // Stride 2
    do_clear(MODE_CNN, 2, 0, 2);
    chk("s2_clear_fill", fill_level, 0);
    push(ramp(0, 1), 8);
    chk("s2_half_valid", out_valid, 0);
    push(ramp(8, 1), 8);
    chk("s2_valid", out_valid, 1);
    chk("s2_data", out_data, ramp(0, 2));
    in_count = 4'd1;
    #1;
    chk("s2_full_ready", in_ready, 0);
    in_count = '0;
    pop(1);
    chk("s2_pop_valid", out_valid, 0);
    chk("s2_pop_data", out_data, 0);
    chk("s2_pop_fill", fill_level, 14);

    // Deconv x2
    do_clear(MODE_CNN, 1, 1, 1);
    push(ramp(10, 1), 8);
    chk("dc_w0", out_data, 64'h000D_000C_000B_000A);
    pop(1);
    chk("dc_w1", out_data, 64'h0E00_0D00_0C00_0B00);
    chk("dc_w1_fill", fill_level, 8);
    pop(1);
    chk("dc_w2", out_data, 64'h000E_000D_000C_000B);
    chk("dc_w2_fill", fill_level, 7);

    // Full / wrap
    do_clear(MODE_CNN, 1, 0, 4);
    push(ramp(8'h20, 1), 8);
    push(ramp(8'h28, 1), 4);
    chk("fw_fill12", fill_level, 12);
    in_valid = 1'b1; in_count = 4'd8; in_data = ramp(8'h2C, 1); out_ready = 1'b1;
    #1;
    chk("fw_ready_blocked", in_ready, 0);
    tick();
    out_ready = 1'b0;
    #1;
    chk("fw_ready_after_pop", in_ready, 1);
    tick();
    in_valid = 1'b0; in_count = '0;
    #1;
    chk("fw_fill16", fill_level, 16);
    pop(2);
    chk("fw_wrap_data", out_data, ramp(8'h2C, 1));
    chk("fw_wrap_fill", fill_level, 8);

    // Protocol error: oversized beat dropped
    pop(1);
    in_count = 4'd9;
    #1;
    chk("er_ready_space", in_ready, 1);
    push(ramp(1, 1), 9);
    chk("er_err", err, 1);
    chk("er_fill", fill_level, 4);

    // Clear beats simultaneous push and pop
    push(ramp(8'h50, 1), 8);
    chk("cl_pre_valid", out_valid, 1);
    in_valid = 1'b1; in_count = 4'd8; out_ready = 1'b1;
    do_clear(MODE_CNN, 1, 0, 1);
    in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
    #1;
    chk("cl_fill", fill_level, 0);
    chk("cl_valid", out_valid, 0);
    chk("cl_err", err, 0);

    // Illegal config: stride 2 with zero insertion falls back to stride 1
    do_clear(MODE_CNN, 2, 1, 1);
    chk("cf_err", err, 1);
    push(ramp(8'h40, 1), 8);
    chk("cf_data", out_data, ramp(8'h40, 1));

    // FC bypass
    do_clear(MODE_FC, 1, 0, 1);
    chk("fc_err_clr", err, 0);
    in_valid = 1'b1; in_count = 4'd8; in_data = 64'h0123_4567_89AB_CDEF; out_ready = 1'b0;
    #1;
    chk("fc_valid", out_valid, 1);
    chk("fc_data", out_data, 64'h0123_4567_89AB_CDEF);
    chk("fc_ready_lo", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("fc_ready_hi", in_ready, 1);
    tick();
    chk("fc_fill", fill_level, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("fc_valid_lo", out_valid, 0);

    // Async reset mid-push
    do_clear(MODE_CNN, 1, 0, 1);
    push(ramp(8'h60, 1), 8);
    chk("ar_pre_fill", fill_level, 8);
    in_valid = 1'b1; in_count = 4'd4;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_fill", fill_level, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_data", out_data, 0);
    in_valid = 1'b0; in_count = '0;
    tick();
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
